count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_seq_pkg.sv | 17 +
 rtl/count_core.sv | 37 +++
 rtl/count_sequencer.sv | 114 +++++++++++
 tb/tb_count_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared state encoding and defaults for count_sequencer and its count_core datapath.
package count_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == RUN) || (s == HOLD);
  endfunction

endpackage

// File: rtl/count_core.sv
// Counter register with synchronous load and up/down step; load wins over enable.
module count_core import count_seq_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count_q;
  logic [WIDTH-1:0] w_count_d;

  // Arithmetic wraps naturally modulo 2^WIDTH in both directions.
  always_comb begin
    w_count_d = r_count_q;
    if (i_load) begin
      w_count_d = i_load_val;
    end else if (i_en) begin
      w_count_d = i_dir ? (r_count_q - WIDTH'(1)) : (r_count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= w_count_d;
    end
  end

  assign o_count = r_count_q;

endmodule

// File: rtl/count_sequencer.sv
// Start/stop/hold/reload count sequencer FSM driving a count_core datapath.
// Define COUNT_DOWN_EN to add the dir port (dir=1 counts down); otherwise up-count only.
module count_sequencer import count_seq_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             reload,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] term_val,
`ifdef COUNT_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  state_e           r_state_q;
  state_e           w_state_d;
  logic             r_tc_q;
  logic             w_tc_d;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_en;
  logic             w_dir;
  logic [WIDTH-1:0] w_count;

`ifdef COUNT_DOWN_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  // Stop overrides everything, including start in IDLE and the terminal check.
  always_comb begin
    w_state_d  = r_state_q;
    w_tc_d     = 1'b0;
    w_load     = 1'b0;
    w_load_val = start_val;
    w_en       = 1'b0;
    if (stop) begin
      w_state_d  = IDLE;
      w_load     = 1'b1;
      w_load_val = '0;
    end else begin
      case (r_state_q)
        IDLE: begin
          if (start) begin
            w_load    = 1'b1;
            w_state_d = RUN;
          end
        end
        RUN: begin
          if (hold) begin
            w_state_d = HOLD;
          end else if (w_count == term_val) begin
            if (reload) begin
              w_load = 1'b1;
              w_tc_d = 1'b1;
            end else begin
              w_state_d = DONE;
            end
          end else begin
            w_en = 1'b1;
          end
        end
        HOLD: begin
          if (!hold) begin
            w_state_d = RUN;
          end
        end
        DONE: begin
          w_state_d = IDLE;
        end
        default: begin
          w_state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= IDLE;
      r_tc_q    <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_tc_q    <= w_tc_d;
    end
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_en      (w_en),
    .i_dir     (w_dir),
    .o_count   (w_count)
  );

  assign count = w_count;
  assign busy  = is_busy(r_state_q);
  assign done  = (r_state_q == DONE);
  assign tc    = r_tc_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; the down-count scenario runs only with COUNT_DOWN_EN.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic       reload = 1'b0;
  logic [3:0] start_val = 4'd0;
  logic [3:0] term_val = 4'd0;
`ifdef COUNT_DOWN_EN
  logic       dir = 1'b0;
`endif
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  count_sequencer #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .reload   (reload),
    .start_val(start_val),
    .term_val (term_val),
`ifdef COUNT_DOWN_EN
    .dir      (dir),
`endif
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_checks++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (tc !== 1'b0) $display("FAIL reset_tc got=%b exp=0", tc); else n_pass++;
    start_val = 4'd9;
    start = 1'b1;
    step();
    n_checks++; if (count !== 4'd0 || busy !== 1'b0)
      $display("FAIL reset_holds_over_edge count=%0d busy=%b exp=0/0", count, busy); else n_pass++;
    start = 1'b0;
    #2 rst = 1'b1;
    step();
    n_checks++; if (count !== 4'd0 || busy !== 1'b0)
      $display("FAIL idle_after_reset count=%0d busy=%b exp=0/0", count, busy); else n_pass++;
  endtask

  task automatic test_single_run();
    start_val = 4'd3; term_val = 4'd7; reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (count !== 4'd3 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL run_first count=%0d busy=%b done=%b exp=3/1/0", count, busy, done); else n_pass++;
    for (int i = 4; i <= 7; i++) begin
      step();
      n_checks++; if (count !== 4'(i) || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL run_step count=%0d busy=%b done=%b exp=%0d/1/0", count, busy, done, i);
      else n_pass++;
    end
    step();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd7)
      $display("FAIL run_done done=%b busy=%b count=%0d exp=1/0/7", done, busy, count); else n_pass++;
    step();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd7)
      $display("FAIL run_idle done=%b busy=%b count=%0d exp=0/0/7", done, busy, count); else n_pass++;
    step();
    n_checks++; if (count !== 4'd7) $display("FAIL idle_retain count=%0d exp=7", count); else n_pass++;
  endtask

  task automatic test_single_cycle();
    start_val = 4'd5; term_val = 4'd5; reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (count !== 4'd5 || busy !== 1'b1)
      $display("FAIL equal_run count=%0d busy=%b exp=5/1", count, busy); else n_pass++;
    step();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd5)
      $display("FAIL equal_done done=%b busy=%b count=%0d exp=1/0/5", done, busy, count); else n_pass++;
    step();
  endtask

  task automatic test_reload();
    logic [3:0] seq [10];
    logic       tcx [10];
    seq = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15};
    tcx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    start_val = 4'd14; term_val = 4'd1; reload = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (count !== seq[i] || tc !== tcx[i] || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL reload_seq[%0d] count=%0d tc=%b done=%b busy=%b exp=%0d/%b/0/1",
                 i, count, tc, done, busy, seq[i], tcx[i]);
      else n_pass++;
      if (i < 9) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    reload = 1'b0;
    n_checks++; if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0)
      $display("FAIL reload_stop count=%0d busy=%b tc=%b done=%b exp=0/0/0/0",
               count, busy, tc, done);
    else n_pass++;
  endtask

  task automatic test_hold();
    start_val = 4'd2; term_val = 4'd9; reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    n_checks++; if (count !== 4'd5) $display("FAIL hold_pre count=%0d exp=5", count); else n_pass++;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (count !== 4'd5 || busy !== 1'b1)
        $display("FAIL hold_freeze[%0d] count=%0d busy=%b exp=5/1", i, count, busy); else n_pass++;
    end
    hold = 1'b0;
    step();
    n_checks++; if (count !== 4'd5 || busy !== 1'b1)
      $display("FAIL hold_release count=%0d busy=%b exp=5/1", count, busy); else n_pass++;
    step();
    n_checks++; if (count !== 4'd6 || busy !== 1'b1)
      $display("FAIL hold_resume count=%0d busy=%b exp=6/1", count, busy); else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_stop();
    start_val = 4'd1; term_val = 4'd10; reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    n_checks++; if (count !== 4'd4) $display("FAIL stop_pre count=%0d exp=4", count); else n_pass++;
    stop = 1'b1; start = 1'b1;
    step();
    n_checks++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL stop_run count=%0d busy=%b done=%b exp=0/0/0", count, busy, done); else n_pass++;
    step();
    n_checks++; if (count !== 4'd0 || busy !== 1'b0)
      $display("FAIL stop_start_idle count=%0d busy=%b exp=0/0", count, busy); else n_pass++;
    stop = 1'b0; start = 1'b0;
    step();
    n_checks++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL stop_after count=%0d busy=%b done=%b exp=0/0/0", count, busy, done); else n_pass++;
  endtask

  task automatic test_async_reset();
    start_val = 4'd0; term_val = 4'd15; reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    n_checks++; if (count !== 4'd2 || busy !== 1'b1)
      $display("FAIL areset_pre count=%0d busy=%b exp=2/1", count, busy); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || busy !== 1'b0)
      $display("FAIL areset_immediate count=%0d busy=%b exp=0/0", count, busy); else n_pass++;
    start_val = 4'd6;
    start = 1'b1;
    step();
    n_checks++; if (count !== 4'd0 || busy !== 1'b0)
      $display("FAIL areset_edge count=%0d busy=%b exp=0/0", count, busy); else n_pass++;
    #2 rst = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (count !== 4'd6 || busy !== 1'b1)
      $display("FAIL areset_resume count=%0d busy=%b exp=6/1", count, busy); else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

`ifdef COUNT_DOWN_EN
  task automatic test_down();
    logic [3:0] seq [5];
    seq = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    dir = 1'b1; start_val = 4'd2; term_val = 4'd14; reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (count !== seq[i] || busy !== 1'b1)
        $display("FAIL down_seq[%0d] count=%0d busy=%b exp=%0d/1", i, count, busy, seq[i]);
      else n_pass++;
      step();
    end
    n_checks++; if (done !== 1'b1 || count !== 4'd14)
      $display("FAIL down_done done=%b count=%0d exp=1/14", done, count); else n_pass++;
    step();
    dir = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_run();
    test_single_cycle();
    test_reload();
    test_hold();
    test_stop();
    test_async_reset();
`ifdef COUNT_DOWN_EN
    test_down();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
